// File: rtl/zoh_channel_sched_if.sv
// zoh_channel_sched_if: DDS sample bank, enables and divide control in; held sample, tick and ack out.
interface zoh_channel_sched_if #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 8
);
    logic [4*DATA_W-1:0] dds_in;
    logic [3:0]          ch_en;
    logic                div_load;
    logic [DIV_W-1:0]    div_value;
    logic [DATA_W-1:0]   hold_out;
    logic [1:0]          hold_ch;
    logic                tick;
    logic [3:0]          ch_ack;
    logic                running;

    modport master (
        output dds_in, ch_en, div_load, div_value,
        input  hold_out, hold_ch, tick, ch_ack, running
    );

    modport slave (
        input  dds_in, ch_en, div_load, div_value,
        output hold_out, hold_ch, tick, ch_ack, running
    );
endinterface

// File: rtl/zoh_channel_sched.sv
// zoh_channel_sched: round-robin zero-order-hold sampler sharing one output slot among 4 DDS channels.
module zoh_channel_sched #(
    parameter int DATA_W      = 16,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 40
) (
    input logic clk,
    input logic reset,
    zoh_channel_sched_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t            r_state, w_state;
    logic [DIV_W-1:0]  r_cnt, w_cnt;
    logic [DIV_W-1:0]  r_div, w_div;
    logic [DIV_W-1:0]  r_pend, w_pend;
    logic              r_pend_valid, w_pend_valid;
    logic [1:0]        r_last_ch, w_last_ch;
    logic [DATA_W-1:0] r_hold_out, w_hold_out;
    logic [1:0]        r_hold_ch, w_hold_ch;
    logic              r_tick, w_tick;
    logic [3:0]        r_ch_ack, w_ch_ack;
    logic              r_running, w_running;
    logic [DIV_W-1:0]  w_clamped;
    logic              w_found;
    logic [1:0]        w_sel;
    logic              w_tick_edge;

    assign w_clamped   = (bus.div_value < DIV_W'(2)) ? DIV_W'(2) : bus.div_value;
    assign w_tick_edge = (r_state == RUN) && (r_cnt == r_div - DIV_W'(1));

    // search starts just after the last served channel and wraps back to it
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last_ch;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && bus.ch_en[r_last_ch + 2'(k)]) begin
                w_found = 1'b1;
                w_sel   = r_last_ch + 2'(k);
            end
        end
    end

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_div        = r_div;
        w_pend       = r_pend;
        w_pend_valid = r_pend_valid;
        w_last_ch    = r_last_ch;
        w_hold_out   = r_hold_out;
        w_hold_ch    = r_hold_ch;
        w_tick       = 1'b0;
        w_ch_ack     = 4'b0000;
        w_running    = r_running;
        if (r_state == IDLE) begin
            w_cnt = '0;
            w_div = bus.div_load ? w_clamped : r_div;
            if (bus.ch_en != 4'b0000) begin
                w_state   = RUN;
                w_running = 1'b1;
            end
        end else begin
            w_cnt = r_cnt + DIV_W'(1);
            if (w_tick_edge) begin
                w_cnt        = '0;
                w_div        = r_pend_valid ? r_pend : r_div;
                w_pend_valid = 1'b0;
                if (w_found) begin
                    w_hold_out = bus.dds_in[32'(w_sel) * DATA_W +: DATA_W];
                    w_hold_ch  = w_sel;
                    w_last_ch  = w_sel;
                    w_tick     = 1'b1;
                    w_ch_ack   = 4'b0001 << w_sel;
                end else begin
                    w_state   = IDLE;
                    w_running = 1'b0;
                end
            end
            // a load on the tick edge lands in pend after the old pend was consumed
            if (bus.div_load) begin
                w_pend       = w_clamped;
                w_pend_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_div        <= DIV_W'(DEFAULT_DIV);
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_last_ch    <= 2'd3;
            r_hold_out   <= '0;
            r_hold_ch    <= 2'd0;
            r_tick       <= 1'b0;
            r_ch_ack     <= 4'b0000;
            r_running    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_div        <= w_div;
            r_pend       <= w_pend;
            r_pend_valid <= w_pend_valid;
            r_last_ch    <= w_last_ch;
            r_hold_out   <= w_hold_out;
            r_hold_ch    <= w_hold_ch;
            r_tick       <= w_tick;
            r_ch_ack     <= w_ch_ack;
            r_running    <= w_running;
        end
    end

    assign bus.hold_out = r_hold_out;
    assign bus.hold_ch  = r_hold_ch;
    assign bus.tick     = r_tick;
    assign bus.ch_ack   = r_ch_ack;
    assign bus.running  = r_running;
endmodule
